bmw_tree_scheduler: RTL and testbench

BMW_TREE_SCHEDULER -- requirements
Module: bmw_tree_scheduler

---
 rtl/bmw_sched_pkg.sv | 17 +
 rtl/bmw_rr_arb.sv | 32 +++
 rtl/bmw_tree_scheduler.sv | 151 +++++++++++++++
 tb/tb_bmw_tree_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bmw_sched_pkg.sv
// Shared encodings for the BMW tree scheduler: request op codes, FSM states
// and an index-width helper that stays legal for single-tree builds.
package bmw_sched_pkg;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   typedef enum logic [0:0] {
      ST_ISSUE   = 1'b0,
      ST_POP_GAP = 1'b1
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bmw_rr_arb.sv
// Round-robin selector: first eligible requester at or after the pointer wins,
// returned both as a one-hot grant and as a binary index.
module bmw_rr_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  elig_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   // Rotating priority scan starting at ptr_i.
   always_comb begin
      int   k;
      logic hit;
      logic found;
      k       = 0;
      hit     = 1'b0;
      found   = 1'b0;
      grant_o = '0;
      idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         k          = (int'(ptr_i) + i) % N;
         hit        = !found && elig_i[k];
         grant_o[k] = hit;
         idx_o      = hit ? IW'(k) : idx_o;
         found      = found | hit;
      end
   end

endmodule

// File: rtl/bmw_tree_scheduler.sv
// Front-end scheduler multiplexing per-tree push/pop requests onto one BMW root.
// Optional macro BMW_SCHED_OCC_CHECK_EN adds per-tree occupancy counters and gating.
module bmw_tree_scheduler
   import bmw_sched_pkg::*;
#(
   parameter int PTW      = 16,
   parameter int MTW      = 0,
   parameter int TREE_NUM = 4,
   parameter int TREE_CAP = 15,
   localparam int DW      = MTW + PTW,
   localparam int TIDW    = idx_width(TREE_NUM),
   localparam int CNTW    = $clog2(TREE_CAP + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic [TREE_NUM-1:0]      i_req_valid,
   input  logic [TREE_NUM-1:0]      i_req_op,
   input  logic [TREE_NUM*DW-1:0]   i_req_data,
   output logic [TREE_NUM-1:0]      o_req_ready,
   output logic                     o_push,
   output logic                     o_pop,
   output logic [DW-1:0]            o_push_data,
   output logic [TIDW-1:0]          o_tree_id,
   input  logic [DW-1:0]            i_pop_data,
   output logic                     o_resp_valid,
   output logic [DW-1:0]            o_resp_data,
   output logic [TIDW-1:0]          o_resp_tree_id,
   output logic [TREE_NUM*CNTW-1:0] o_occ
);

   state_e              state_q;
   logic [TIDW-1:0]     rr_q;
   logic                pend_q;
   logic [TIDW-1:0]     pend_tid_q;
   logic                resp_valid_q;
   logic [DW-1:0]       resp_data_q;
   logic [TIDW-1:0]     resp_tid_q;

   logic [TREE_NUM-1:0] elig_s;
   logic [TREE_NUM-1:0] arb_grant_s;
   logic [TREE_NUM-1:0] grant_s;
   logic [TIDW-1:0]     arb_idx_s;
   logic                issue_s;
   logic                any_s;
   logic                op_s;
   logic                push_s;
   logic                pop_s;
   logic [DW-1:0]       sel_data_s;

`ifdef BMW_SCHED_OCC_CHECK_EN
   logic [CNTW-1:0] occ_q [TREE_NUM];

   // A tree may push only below capacity and pop only when non-empty.
   always_comb begin
      elig_s = '0;
      for (int k = 0; k < TREE_NUM; k++) begin
         elig_s[k] = i_req_valid[k] &
                     ((i_req_op[k] == OP_POP) ? (occ_q[k] != '0)
                                              : (occ_q[k] < CNTW'(TREE_CAP)));
      end
   end

   // Occupancy follows granted commands; the gating above prevents wrap.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int k = 0; k < TREE_NUM; k++) occ_q[k] <= '0;
      end else begin
         for (int k = 0; k < TREE_NUM; k++) begin
            if (grant_s[k]) begin
               occ_q[k] <= push_s ? occ_q[k] + CNTW'(1) : occ_q[k] - CNTW'(1);
            end else begin
               occ_q[k] <= occ_q[k];
            end
         end
      end
   end

   // Pack counters, tree k at [k*CNTW +: CNTW].
   always_comb begin
      o_occ = '0;
      for (int k = 0; k < TREE_NUM; k++) o_occ[k*CNTW +: CNTW] = occ_q[k];
   end
`else
   assign elig_s = i_req_valid;
   assign o_occ  = '0;
`endif

   bmw_rr_arb #(
      .N  (TREE_NUM),
      .IW (TIDW)
   ) u_arb (
      .elig_i  (elig_s),
      .ptr_i   (rr_q),
      .grant_o (arb_grant_s),
      .idx_o   (arb_idx_s)
   );

   // Grants only in ISSUE; reset also blanks the combinational command path.
   always_comb begin
      issue_s = (state_q == ST_ISSUE) && i_arst_n;
      if (issue_s) begin
         grant_s = arb_grant_s;
      end else begin
         grant_s = '0;
      end
      any_s      = |grant_s;
      op_s       = i_req_op[arb_idx_s];
      push_s     = any_s && (op_s == OP_PUSH);
      pop_s      = any_s && (op_s == OP_POP);
      sel_data_s = i_req_data[int'(arb_idx_s)*DW +: DW];
   end

   assign o_req_ready    = grant_s;
   assign o_push         = push_s;
   assign o_pop          = pop_s;
   assign o_push_data    = push_s ? sel_data_s : '0;
   assign o_tree_id      = any_s ? arb_idx_s : '0;
   assign o_resp_valid   = resp_valid_q;
   assign o_resp_data    = resp_data_q;
   assign o_resp_tree_id = resp_tid_q;

   // Issue FSM, round-robin pointer and the two-stage pop response pipeline.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q      <= ST_ISSUE;
         rr_q         <= '0;
         pend_q       <= 1'b0;
         pend_tid_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_tid_q   <= '0;
      end else begin
         case (state_q)
            ST_ISSUE:   state_q <= pop_s ? ST_POP_GAP : ST_ISSUE;
            ST_POP_GAP: state_q <= ST_ISSUE;
            default:    state_q <= ST_ISSUE;
         endcase
         if (any_s) begin
            rr_q <= TIDW'((int'(arb_idx_s) + 1) % TREE_NUM);
         end else begin
            rr_q <= rr_q;
         end
         pend_q       <= pop_s;
         pend_tid_q   <= pop_s ? arb_idx_s : '0;
         resp_valid_q <= pend_q;
         resp_data_q  <= pend_q ? i_pop_data : '0;
         resp_tid_q   <= pend_q ? pend_tid_q : '0;
      end
   end

endmodule

// File: tb/tb_bmw_tree_scheduler.sv
// Directed table-driven bench for bmw_tree_scheduler (default 4 trees, 16-bit data),
// with expectations selected for builds with or without BMW_SCHED_OCC_CHECK_EN.
module tb_bmw_tree_scheduler;

`ifdef BMW_SCHED_OCC_CHECK_EN
   localparam bit OCC_EN = 1'b1;
`else
   localparam bit OCC_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_arst_n = 1'b0;
   logic [3:0]  i_req_valid = '0;
   logic [3:0]  i_req_op = '0;
   logic [63:0] i_req_data = '0;
   logic [3:0]  o_req_ready;
   logic        o_push;
   logic        o_pop;
   logic [15:0] o_push_data;
   logic [1:0]  o_tree_id;
   logic [15:0] i_pop_data = '0;
   logic        o_resp_valid;
   logic [15:0] o_resp_data;
   logic [1:0]  o_resp_tree_id;
   logic [15:0] o_occ;

   int checks = 0;
   int errors = 0;

   bmw_tree_scheduler dut (
      .i_clk          (i_clk),
      .i_arst_n       (i_arst_n),
      .i_req_valid    (i_req_valid),
      .i_req_op       (i_req_op),
      .i_req_data     (i_req_data),
      .o_req_ready    (o_req_ready),
      .o_push         (o_push),
      .o_pop          (o_pop),
      .o_push_data    (o_push_data),
      .o_tree_id      (o_tree_id),
      .i_pop_data     (i_pop_data),
      .o_resp_valid   (o_resp_valid),
      .o_resp_data    (o_resp_data),
      .o_resp_tree_id (o_resp_tree_id),
      .o_occ          (o_occ)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  op;
      logic [63:0] data;
      logic [15:0] popd;
      logic [3:0]  e_ready;
      logic        e_push;
      logic        e_pop;
      logic [1:0]  e_tid;
      logic [15:0] e_pdata;
      logic        e_rv;
      logic [15:0] e_rd;
      logic [1:0]  e_rtid;
      logic [15:0] e_occ;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   localparam logic [63:0] DALL = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
   localparam logic [63:0] D2   = 64'h0000_0005_0000_0000;
   localparam logic [63:0] D33  = 64'h0033_0000_0000_0000;

   function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] op,
                               input logic [63:0] data, input logic [15:0] popd,
                               input logic [3:0] e_ready, input logic e_push, input logic e_pop,
                               input logic [1:0] e_tid, input logic [15:0] e_pdata,
                               input logic e_rv, input logic [15:0] e_rd, input logic [1:0] e_rtid,
                               input logic [15:0] e_occ);
      vec_t v;
      v.rst = rst; v.valid = valid; v.op = op; v.data = data; v.popd = popd;
      v.e_ready = e_ready; v.e_push = e_push; v.e_pop = e_pop; v.e_tid = e_tid;
      v.e_pdata = e_pdata; v.e_rv = e_rv; v.e_rd = e_rd; v.e_rtid = e_rtid; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_reset();
      i_arst_n = 1'b0;
      #1;
      i_arst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // single push to tree 2
      tbl[0]  = mk(1'b1, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[1]  = mk(1'b0, 4'b0100, 4'b0000, D2,    16'h0,    4'b0100, 1'b1, 1'b0, 2'd2, 16'h0005, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[2]  = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0100);
      // all trees push continuously from a fresh pointer
      tbl[3]  = mk(1'b1, 4'b1111, 4'b0000, DALL,  16'h0,    4'b0001, 1'b1, 1'b0, 2'd0, 16'h00A0, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[4]  = mk(1'b0, 4'b1111, 4'b0000, DALL,  16'h0,    4'b0010, 1'b1, 1'b0, 2'd1, 16'h00A1, 1'b0, 16'h0000, 2'd0, 16'h0001);
      tbl[5]  = mk(1'b0, 4'b1111, 4'b0000, DALL,  16'h0,    4'b0100, 1'b1, 1'b0, 2'd2, 16'h00A2, 1'b0, 16'h0000, 2'd0, 16'h0011);
      tbl[6]  = mk(1'b0, 4'b1111, 4'b0000, DALL,  16'h0,    4'b1000, 1'b1, 1'b0, 2'd3, 16'h00A3, 1'b0, 16'h0000, 2'd0, 16'h0111);
      tbl[7]  = mk(1'b0, 4'b1111, 4'b0000, DALL,  16'h0,    4'b0001, 1'b1, 1'b0, 2'd0, 16'h00A0, 1'b0, 16'h0000, 2'd0, 16'h1111);
      tbl[8]  = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h1112);
      // pop from tree 1, gap cycle ignores requests, response two cycles later
      tbl[9]  = mk(1'b0, 4'b0010, 4'b0010, 64'h0, 16'h0,    4'b0010, 1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h1112);
      tbl[10] = mk(1'b0, 4'b1111, 4'b0000, DALL,  16'h0003, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h1102);
      tbl[11] = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h7777, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 16'h0003, 2'd1, 16'h1102);
      tbl[12] = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h1102);
      // tree 0 pops while empty, tree 3 pushes
`ifdef BMW_SCHED_OCC_CHECK_EN
      tbl[13] = mk(1'b1, 4'b1001, 4'b0001, D33,   16'h0,    4'b1000, 1'b1, 1'b0, 2'd3, 16'h0033, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[14] = mk(1'b0, 4'b1001, 4'b0001, D33,   16'h00AB, 4'b1000, 1'b1, 1'b0, 2'd3, 16'h0033, 1'b0, 16'h0000, 2'd0, 16'h1000);
      tbl[15] = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h2000);
`else
      tbl[13] = mk(1'b1, 4'b1001, 4'b0001, D33,   16'h0,    4'b0001, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[14] = mk(1'b0, 4'b1001, 4'b0001, D33,   16'h00AB, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 2'd0, 16'h0000);
      tbl[15] = mk(1'b0, 4'b0000, 4'b0000, 64'h0, 16'h0,    4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 16'h00AB, 2'd0, 16'h0000);
`endif

      #12;
      i_arst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(posedge i_clk);
         #1;
         if (tbl[i].rst) pulse_reset();
         i_req_valid = tbl[i].valid;
         i_req_op    = tbl[i].op;
         i_req_data  = tbl[i].data;
         i_pop_data  = tbl[i].popd;
         @(negedge i_clk);
         chk($sformatf("v%0d ready", i), 32'(o_req_ready), 32'(tbl[i].e_ready));
         chk($sformatf("v%0d push", i), 32'(o_push), 32'(tbl[i].e_push));
         chk($sformatf("v%0d pop", i), 32'(o_pop), 32'(tbl[i].e_pop));
         chk($sformatf("v%0d tree_id", i), 32'(o_tree_id), 32'(tbl[i].e_tid));
         chk($sformatf("v%0d push_data", i), 32'(o_push_data), 32'(tbl[i].e_pdata));
         chk($sformatf("v%0d resp_valid", i), 32'(o_resp_valid), 32'(tbl[i].e_rv));
         chk($sformatf("v%0d resp_data", i), 32'(o_resp_data), 32'(tbl[i].e_rd));
         chk($sformatf("v%0d resp_tree", i), 32'(o_resp_tree_id), 32'(tbl[i].e_rtid));
         chk($sformatf("v%0d occ", i), 32'(o_occ), OCC_EN ? 32'(tbl[i].e_occ) : 32'd0);
      end

      // capacity: sixteen pushes to tree 1, the last one is held when counting
      @(posedge i_clk);
      #1;
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(posedge i_clk);
            #1;
         end
         i_req_valid = 4'b0010;
         i_req_op    = 4'b0000;
         i_req_data  = 64'h0000_0000_0100_0000 + (64'(i) << 16);
         @(negedge i_clk);
         chk($sformatf("cap push%0d ready", i), 32'(o_req_ready),
             ((i < 15) || !OCC_EN) ? 32'h2 : 32'h0);
      end
      @(posedge i_clk);
      #1;
      i_req_valid = 4'b0000;
      @(negedge i_clk);
      chk("cap occ", 32'(o_occ), OCC_EN ? 32'h00F0 : 32'h0);

      // reset during the gap cycle of a pop
      @(posedge i_clk);
      #1;
      pulse_reset();
      i_req_valid = 4'b0100;
      i_req_op    = 4'b0000;
      i_req_data  = 64'h0000_0022_0000_0000;
      @(negedge i_clk);
      chk("rst pre push", 32'(o_push), 32'h1);
      @(posedge i_clk);
      #1;
      i_req_op = 4'b0100;
      @(negedge i_clk);
      chk("rst pre pop", 32'(o_pop), 32'h1);
      @(posedge i_clk);
      #1;
      i_req_valid = 4'b1111;
      i_req_op    = 4'b0000;
      i_req_data  = DALL;
      i_pop_data  = 16'h5A5A;
      i_arst_n    = 1'b0;
      #1;
      chk("in rst ready", 32'(o_req_ready), 32'h0);
      chk("in rst push", 32'(o_push), 32'h0);
      chk("in rst occ", 32'(o_occ), 32'h0);
      chk("in rst resp_valid", 32'(o_resp_valid), 32'h0);
      @(negedge i_clk);
      i_req_valid = 4'b0000;
      i_arst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk($sformatf("post rst resp_valid c%0d", i), 32'(o_resp_valid), 32'h0);
      end
      chk("post rst occ", 32'(o_occ), 32'h0);
      @(posedge i_clk);
      #1;
      i_req_valid = 4'b1111;
      @(negedge i_clk);
      chk("post rst rr grant", 32'(o_req_ready), 32'h1);
      @(posedge i_clk);
      #1;
      i_req_valid = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
